// File: rtl/tick_debouncer.sv
// Debounces a raw pushbutton, sampling it on every rising edge of a slow divided clock seen as data.
// Optional auto-repeat of btn_press while held: define TICK_DEBOUNCER_AUTOREPEAT_EN.
module tick_debouncer #(
  parameter int unsigned STABLE_SAMPLES = 32'd4,
  parameter int unsigned COUNT_W        = 32'd8,
  parameter int unsigned REPEAT_DELAY   = 32'd50,
  parameter int unsigned REPEAT_PERIOD  = 32'd10
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               slow_clk,
  input  logic               btn_raw,
  output logic               sample_tick,
  output logic               btn_level,
  output logic               btn_press,
  output logic               btn_release,
  output logic [COUNT_W-1:0] press_count
);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_SAMPLES);

  if ((STABLE_SAMPLES < 32'd2) || (STABLE_SAMPLES > 32'd255) ||
      (REPEAT_DELAY < 32'd1) || (REPEAT_PERIOD < 32'd1)) begin : g_param_check
    $error("tick_debouncer: parameter out of legal range");
  end

  logic       slow_meta;
  logic       slow_s;
  logic       slow_prev;
  logic       btn_meta;
  logic       btn_s;
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] stable_cnt;
  logic [7:0] stable_cnt_nxt;
  logic [7:0] cnt_inc;
  logic       press_nxt;
  logic       release_nxt;
  logic       press_any;

  assign cnt_inc = stable_cnt + 8'd1;

  // Two-flop synchronisers plus slow_clk rising-edge detector.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      slow_meta   <= 1'b0;
      slow_s      <= 1'b0;
      slow_prev   <= 1'b0;
      btn_meta    <= 1'b0;
      btn_s       <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      slow_meta   <= slow_clk;
      slow_s      <= slow_meta;
      slow_prev   <= slow_s;
      btn_meta    <= btn_raw;
      btn_s       <= btn_meta;
      sample_tick <= slow_s & ~slow_prev;
    end
  end

  // Debounce FSM next-state; only a tick may move it.
  always_comb begin
    state_nxt      = state;
    stable_cnt_nxt = stable_cnt;
    press_nxt      = 1'b0;
    release_nxt    = 1'b0;
    if (sample_tick) begin
      case (state)
        ST_IDLE: begin
          if (btn_s) begin
            state_nxt      = ST_PRESS_WAIT;
            stable_cnt_nxt = 8'd1;
          end else begin
            stable_cnt_nxt = 8'd0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!btn_s) begin
            state_nxt      = ST_IDLE;
            stable_cnt_nxt = 8'd0;
          end else if (cnt_inc == STABLE_LIM) begin
            state_nxt      = ST_HELD;
            stable_cnt_nxt = 8'd0;
            press_nxt      = 1'b1;
          end else begin
            stable_cnt_nxt = cnt_inc;
          end
        end
        ST_HELD: begin
          if (!btn_s) begin
            state_nxt      = ST_RELEASE_WAIT;
            stable_cnt_nxt = 8'd1;
          end else begin
            stable_cnt_nxt = 8'd0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (btn_s) begin
            state_nxt      = ST_HELD;
            stable_cnt_nxt = 8'd0;
          end else if (cnt_inc == STABLE_LIM) begin
            state_nxt      = ST_IDLE;
            stable_cnt_nxt = 8'd0;
            release_nxt    = 1'b1;
          end else begin
            stable_cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt      = ST_IDLE;
          stable_cnt_nxt = 8'd0;
        end
      endcase
    end else begin
      state_nxt      = state;
      stable_cnt_nxt = stable_cnt;
    end
  end

`ifdef TICK_DEBOUNCER_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 32'd1);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_nxt;
  logic [RPT_W-1:0] rpt_inc;
  logic [RPT_W-1:0] rpt_lim;
  logic             rpt_on;
  logic             rpt_on_nxt;
  logic             rpt_fire;

  // Repeat counter: first fire after REPEAT_DELAY held ticks, then every REPEAT_PERIOD.
  always_comb begin
    rpt_cnt_nxt = rpt_cnt;
    rpt_on_nxt  = rpt_on;
    rpt_fire    = 1'b0;
    rpt_inc     = rpt_cnt + RPT_W'(1);
    rpt_lim     = rpt_on ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
    if (state == ST_IDLE) begin
      rpt_cnt_nxt = '0;
      rpt_on_nxt  = 1'b0;
    end else if (sample_tick && (state == ST_HELD) && btn_s) begin
      if (rpt_inc == rpt_lim) begin
        rpt_cnt_nxt = '0;
        rpt_on_nxt  = 1'b1;
        rpt_fire    = 1'b1;
      end else begin
        rpt_cnt_nxt = rpt_inc;
      end
    end else begin
      rpt_cnt_nxt = rpt_cnt;
    end
  end

  // Repeat counter state; frozen outside HELD until IDLE clears it.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rpt_cnt <= '0;
      rpt_on  <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt_nxt;
      rpt_on  <= rpt_on_nxt;
    end
  end

  assign press_any = press_nxt | rpt_fire;
`else
  assign press_any = press_nxt;
`endif

  // FSM state and registered outputs; level moves together with its pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= ST_IDLE;
      stable_cnt  <= 8'd0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_nxt;
      stable_cnt  <= stable_cnt_nxt;
      btn_level   <= (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE_WAIT);
      btn_press   <= press_any;
      btn_release <= release_nxt;
      if (press_any) begin
        press_count <= press_count + COUNT_W'(1);
      end else begin
        press_count <= press_count;
      end
    end
  end

endmodule

// File: tb/tb_tick_debouncer.sv
// Randomised bench for tick_debouncer against a run-length reference model; honours TICK_DEBOUNCER_AUTOREPEAT_EN.
module tb_tick_debouncer;

  localparam int unsigned SS = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned RD = 5;
  localparam int unsigned RP = 2;
`ifdef TICK_DEBOUNCER_AUTOREPEAT_EN
  localparam int EXP_AR_PRESSES = 5;
`else
  localparam int EXP_AR_PRESSES = 1;
`endif

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          slow_clk = 1'b0;
  logic          btn_raw = 1'b0;
  logic          sample_tick;
  logic          btn_level;
  logic          btn_press;
  logic          btn_release;
  logic [CW-1:0] press_count;

  tick_debouncer #(
    .STABLE_SAMPLES(SS), .COUNT_W(CW), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_in(clk_in), .rst(rst), .slow_clk(slow_clk), .btn_raw(btn_raw),
    .sample_tick(sample_tick), .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .press_count(press_count)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pin history, then tick-level run-length debouncing.
  logic [3:0] m_sh;
  logic [1:0] m_bh;
  logic       m_tick, m_bs, m_level, m_press, m_release;
  int         m_run, m_held, m_count;

  int  per = 8;
  int  phase = 0;
  bit  stall = 1'b0;
  int  obs_press, obs_release, obs_tick;
  logic [CW-1:0] press_log[$];
  int  exp_seq[5] = '{1, 2, 3, 0, 1};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic sc, input logic br);
    if (r) begin
      m_sh = 4'd0; m_bh = 2'd0; m_tick = 1'b0; m_bs = 1'b0;
      m_level = 1'b0; m_press = 1'b0; m_release = 1'b0;
      m_run = 0; m_held = 0; m_count = 0;
    end else begin
      m_press = 1'b0;
      m_release = 1'b0;
      if (m_tick) begin
        if (m_bs != m_level) begin
          m_run++;
          if (m_run == int'(SS)) begin
            m_run = 0;
            m_level = m_bs;
            if (m_level) begin
              m_press = 1'b1;
              m_count = (m_count + 1) % (1 << CW);
            end else begin
              m_release = 1'b1;
              m_held = 0;
            end
          end
        end else begin
`ifdef TICK_DEBOUNCER_AUTOREPEAT_EN
          if (m_level && (m_run == 0)) begin
            m_held++;
            if ((m_held == int'(RD)) || ((m_held > int'(RD)) && (((m_held - int'(RD)) % int'(RP)) == 0))) begin
              m_press = 1'b1;
              m_count = (m_count + 1) % (1 << CW);
            end
          end
`endif
          m_run = 0;
        end
      end
      m_sh = {m_sh[2:0], sc};
      m_bh = {m_bh[0], br};
      m_tick = m_sh[2] & ~m_sh[3];
      m_bs = m_bh[1];
    end
  endtask

  task automatic step(input logic r, input logic b);
    rst = r;
    btn_raw = b;
    slow_clk = stall ? 1'b0 : (phase >= per / 2);
    phase = (phase + 1) % per;
    @(posedge clk_in);
    model_edge(r, slow_clk, b);
    #1;
    check_val("sample_tick", 32'(sample_tick), 32'(m_tick));
    check_val("btn_level", 32'(btn_level), 32'(m_level));
    check_val("btn_press", 32'(btn_press), 32'(m_press));
    check_val("btn_release", 32'(btn_release), 32'(m_release));
    check_val("press_count", 32'(press_count), 32'(m_count));
    check_val("press_release_overlap", 32'(btn_press & btn_release), 32'd0);
    if (btn_press) begin
      obs_press++;
      press_log.push_back(press_count);
    end
    if (btn_release) obs_release++;
    if (sample_tick) obs_tick++;
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) step(1'b0, b);
  endtask

  task automatic bounce(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic clear_obs();
    obs_press = 0; obs_release = 0; obs_tick = 0;
    press_log.delete();
  endtask

  initial begin
    int   len;
    logic v;
    clear_obs();

    // Reset with the button pressed and slow_clk running.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check_val("rst_count", 32'(press_count), 32'd0);
      check_val("rst_level", 32'(btn_level), 32'd0);
    end
    step(1'b0, 1'b0);
    check_val("post_rst_count", 32'(press_count), 32'd0);

    // Clean press then clean release.
    hold(1'b0, 2 * per);
    clear_obs();
    hold(1'b1, (SS + 2) * per);
    check_val("clean_press_pulses", 32'(obs_press), 32'd1);
    check_val("clean_press_level", 32'(btn_level), 32'd1);
    check_val("clean_press_count", 32'(press_count), 32'd1);
    hold(1'b0, (SS + 2) * per);
    check_val("clean_release_pulses", 32'(obs_release), 32'd1);

    // Bounce 1,1,0,1,1,1,1 across ticks, then keep pressed.
    clear_obs();
    foreach (exp_seq[i]) begin end
    hold(1'b1, per); hold(1'b1, per); hold(1'b0, per);
    hold(1'b1, 4 * per); hold(1'b1, 3 * per);
    check_val("bounce_pulses", 32'(obs_press), 32'd1);
    hold(1'b0, (SS + 2) * per);

    // Five press/release pairs wrap a 2-bit counter.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    clear_obs();
    for (int p = 0; p < 5; p++) begin
      bounce(int'($urandom_range(0, 2 * per)));
      hold(1'b1, (SS + 2) * per);
      hold(1'b0, (SS + 2) * per);
    end
    check_val("wrap_log_size", 32'(press_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < press_log.size(); i++)
      check_val("wrap_seq", 32'(press_log[i]), 32'(exp_seq[i]));
    check_val("wrap_releases", 32'(obs_release), 32'd5);

    // Randomised soak: periods, bounce, stalls and resets.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        per = 2 * int'($urandom_range(2, 6));
        phase = 0;
      end
      stall = ($urandom_range(0, 9) == 0);
      v = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 60));
      if ($urandom_range(0, 3) == 0) bounce(len);
      else hold(v, len);
      if ($urandom_range(0, 19) == 0) step(1'b1, v);
    end
    stall = 1'b0;
    per = 8;
    phase = 0;

    // Stall in HELD: no ticks, outputs frozen; then reset mid-HELD.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    hold(1'b1, (SS + 2) * per);
    check_val("stall_pre_level", 32'(btn_level), 32'd1);
    stall = 1'b1;
    hold(1'b1, 4);
    clear_obs();
    bounce(60);
    check_val("stall_ticks", 32'(obs_tick), 32'd0);
    check_val("stall_presses", 32'(obs_press), 32'd0);
    check_val("stall_level", 32'(btn_level), 32'd1);
    check_val("stall_count", 32'(press_count), 32'd1);
    stall = 1'b0;
    step(1'b1, 1'b1);
    check_val("rst_held_level", 32'(btn_level), 32'd0);
    step(1'b0, 1'b0);
    check_val("rst_held_release", 32'(obs_release), 32'd0);

    // Long hold: auto-repeat count when compiled in, single press otherwise.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    hold(1'b0, 2 * per);
    clear_obs();
    for (int i = 0; i < 20 * per && obs_press == 0; i++) step(1'b0, 1'b1);
    check_val("ar_accept", 32'(obs_press), 32'd1);
    hold(1'b1, 12 * per);
    hold(1'b0, (SS + 2) * per);
    check_val("ar_presses", 32'(obs_press), 32'(EXP_AR_PRESSES));
    check_val("ar_count", 32'(press_count), 32'(EXP_AR_PRESSES % (1 << CW)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
